// File: rtl/delay_element_pkg.sv
// delay_element shared types and limits.
// Imported by the interface, stage and top.
package delay_element_pkg;

  localparam int DATA_W    = 32;
  localparam int MAX_DEPTH = 64;

  typedef logic [0:DATA_W-1] sample_t;

endpackage

// File: rtl/delay_element_if.sv
// Sample bus for delay_element: d/en in, q out.
// primed exists only with DELAY_ELEMENT_PRIMED_EN.
interface delay_element_if
  import delay_element_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic               en;
  logic [0:WIDTH-1]   d;
  logic [0:WIDTH-1]   q;
`ifdef DELAY_ELEMENT_PRIMED_EN
  logic               primed;

  modport master (
    output en,
    output d,
    input  q,
    input  primed
  );

  modport slave (
    input  en,
    input  d,
    output q,
    output primed
  );
`else
  modport master (
    output en,
    output d,
    input  q
  );

  modport slave (
    input  en,
    input  d,
    output q
  );
`endif

endinterface

// File: rtl/delay_element_stage.sv
// delay_stage: one WIDTH-bit register with
// sync reset and shift enable.
module delay_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [0:WIDTH-1] d,
  output logic [0:WIDTH-1] q
);

  logic [0:WIDTH-1] r = '0;

  // capture d on enabled edges, clear on reset
  always_ff @(posedge clk) begin
    if (rst)
      r <= '0;
    else if (en)
      r <= d;
  end

  assign q = r;

endmodule

// File: rtl/delay_element.sv
// delay_element: DEPTH-stage z^-k delay line.
// Optional primed flag: DELAY_ELEMENT_PRIMED_EN.
module delay_element
  import delay_element_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 1
) (
  input  logic            clk,
  input  logic            rst,
  delay_element_if.slave  io
);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("delay_element: DEPTH out of range");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("delay_element: WIDTH must be >= 1");
  end

  logic [0:WIDTH-1] din [DEPTH];
  logic [0:WIDTH-1] s   [DEPTH];

  assign din[0] = io.d;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign din[k] = s[k-1];
    end
    delay_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (io.en),
      .d   (din[k]),
      .q   (s[k])
    );
  end

  assign io.q = s[DEPTH-1];

`ifdef DELAY_ELEMENT_PRIMED_EN
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0] cnt = '0;

  // count enabled shifts since reset, saturating at DEPTH
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (io.en && cnt != FULL)
      cnt <= cnt + CW'(1);
  end

  assign io.primed = (cnt == FULL);
`endif

endmodule

// File: tb/tb_delay_element.sv
// Directed bench for delay_element.
// Covers reset, stream, hold, tap chain, depth 4.
module tb_delay_element;
  import delay_element_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  delay_element_if #(.WIDTH(DATA_W)) i1 ();
  delay_element_if #(.WIDTH(DATA_W)) c1 ();
  delay_element_if #(.WIDTH(DATA_W)) c2 ();
  delay_element_if #(.WIDTH(DATA_W)) c3 ();
  delay_element_if #(.WIDTH(DATA_W)) c4 ();
  delay_element_if #(.WIDTH(DATA_W)) i4 ();
  delay_element_if #(.WIDTH(DATA_W)) i3 ();

  delay_element #(.WIDTH(DATA_W), .DEPTH(1))
    u1 (.clk(clk), .rst(rst), .io(i1));
  delay_element #(.WIDTH(DATA_W), .DEPTH(1))
    uc1 (.clk(clk), .rst(rst), .io(c1));
  delay_element #(.WIDTH(DATA_W), .DEPTH(1))
    uc2 (.clk(clk), .rst(rst), .io(c2));
  delay_element #(.WIDTH(DATA_W), .DEPTH(1))
    uc3 (.clk(clk), .rst(rst), .io(c3));
  delay_element #(.WIDTH(DATA_W), .DEPTH(1))
    uc4 (.clk(clk), .rst(rst), .io(c4));
  delay_element #(.WIDTH(DATA_W), .DEPTH(4))
    u4 (.clk(clk), .rst(rst), .io(i4));
  delay_element #(.WIDTH(DATA_W), .DEPTH(3))
    u3 (.clk(clk), .rst(rst), .io(i3));

  sample_t imp = '0;

  assign c1.en = 1'b1;
  assign c2.en = 1'b1;
  assign c3.en = 1'b1;
  assign c4.en = 1'b1;
  assign c1.d  = imp;
  assign c2.d  = c1.q;
  assign c3.d  = c2.q;
  assign c4.d  = c3.q;

  sample_t din [5];
  sample_t tap [4];

  initial begin
    i1.en = 1'b1;
    i1.d  = '0;
    i4.en = 1'b1;
    i4.d  = '0;
    i3.en = 1'b0;
    i3.d  = '0;
    din[0] = sample_t'(0);
    din[1] = sample_t'(1);
    din[2] = sample_t'(-21831);
    din[3] = sample_t'(9770);
    din[4] = sample_t'(-1713);

    // reset with d held at 22290
    @(negedge clk);
    rst  = 1'b1;
    i1.d = sample_t'(22290);
    @(negedge clk);
    chk("rst_q_c1", i1.q, 0);
    @(negedge clk);
    chk("rst_q_c2", i1.q, 0);
    rst = 1'b0;
    chk("rst_q_fall", i1.q, 0);
    @(negedge clk);
    chk("post_rst_q", i1.q, 22290);

    // unit-delay stream
    for (int i = 0; i < 5; i++) begin
      i1.d = din[i];
      @(negedge clk);
      chk($sformatf("stream%0d", i), i1.q, din[i]);
    end
    i1.d = din[2];
    @(negedge clk);
    chk("sign_bit0", 64'(i1.q[0]), 1);
    chk("neg_word", i1.q, 32'hFFFF_AAB9);

    // enable hold
    i1.d = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("load_dead", i1.q, 32'hDEAD_BEEF);
    i1.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i1.d = 32'h1111_0000 + 32'(i);
      @(negedge clk);
      chk($sformatf("hold%0d", i), i1.q, 32'hDEAD_BEEF);
    end
    i1.en = 1'b1;
    i1.d  = 32'h1234_5678;
    @(negedge clk);
    chk("hold_release", i1.q, 32'h1234_5678);

    // impulse through four chained unit delays
    imp = sample_t'(1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      imp  = '0;
      tap[0] = c1.q;
      tap[1] = c2.q;
      tap[2] = c3.q;
      tap[3] = c4.q;
      for (int j = 0; j < 4; j++)
        chk($sformatf("tap%0d_cyc%0d", j + 1, k),
            tap[j], (k == j + 1) ? 1 : 0);
    end

    // depth 4: reset discards in-flight samples
    i4.d = 32'hA1;
    @(negedge clk);
    i4.d = 32'hA2;
    @(negedge clk);
    rst  = 1'b1;
    i4.d = 32'hA3;
    @(negedge clk);
    rst = 1'b0;
    chk("d4_rst_q", i4.q, 0);
    i4.d = 32'h55;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      i4.d = '0;
      chk($sformatf("d4_edge%0d", e), i4.q,
          (e == 4) ? 32'h55 : 0);
    end
    @(negedge clk);
    chk("d4_after", i4.q, 0);

`ifdef DELAY_ELEMENT_PRIMED_EN
    // primed on a depth 3 instance
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("pr_rst", 64'(i3.primed), 0);
    i3.en = 1'b1;
    @(negedge clk);
    chk("pr_e1", 64'(i3.primed), 0);
    i3.en = 1'b0;
    @(negedge clk);
    chk("pr_h1", 64'(i3.primed), 0);
    i3.en = 1'b1;
    @(negedge clk);
    chk("pr_e2", 64'(i3.primed), 0);
    i3.en = 1'b0;
    @(negedge clk);
    chk("pr_h2", 64'(i3.primed), 0);
    i3.en = 1'b1;
    @(negedge clk);
    chk("pr_e3", 64'(i3.primed), 1);
    i3.en = 1'b0;
    @(negedge clk);
    chk("pr_h3", 64'(i3.primed), 1);
    i3.en = 1'b1;
    @(negedge clk);
    chk("pr_sat", 64'(i3.primed), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("pr_rst2", 64'(i3.primed), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
